// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver.
// The rx pin passes through a 2-flop synchroniser. Each bit is decided by a
// 3-sample majority vote around the bit centre. The receiver flags parity,
// framing and overrun errors. Received words leave on a valid/ready handshake.
module uart_rx_cfg #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV_W  = (DIV < 1) ? 1 : $clog2(DIV + 1);
   localparam int OS_W   = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam int SAMP_A = OVERSAMPLE / 2 - 1;
   localparam int SAMP_B = OVERSAMPLE / 2;
   localparam int SAMP_C = OVERSAMPLE / 2 + 1;

   // Parameter legality is checked once, at elaboration.
   if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 ||
       (OVERSAMPLE % 2) != 0 || DIV < 1) begin : g_param_err
      $error("uart_rx_cfg: illegal parameter combination");
   end

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic [DIV_W-1:0]     div_q, div_d;
   logic                 os_tick;
   logic                 sync1_q, sync1_d;
   logic                 rx_s_q, rx_s_d;
   logic [2:0]           state_q, state_d;
   logic                 armed_q, armed_d;
   logic [OS_W-1:0]      samp_cnt_q, samp_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_flag_q, par_flag_d;
   logic                 frm_flag_q, frm_flag_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 vote;
   logic                 at_vote;
   logic                 complete;
   logic                 accept;

   // Free-running oversample divider and the two synchroniser stages.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      div_d   = div_q + DIV_W'(1);
      os_tick = 1'b0;
      if (div_q == DIV_W'(DIV - 1)) begin
         div_d   = '0;
         os_tick = 1'b1;
      end
      sync1_d = rx;
      rx_s_d  = sync1_q;
   end

   // Receive FSM, centre sampling and the valid/ready output handshake.
   always_comb begin
      state_d      = state_q;
      armed_d      = armed_q | ((state_q == ST_IDLE) & rx_s_q);
      samp_cnt_d   = samp_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      samp_d       = samp_q;
      shift_d      = shift_q;
      par_flag_d   = par_flag_q;
      frm_flag_d   = frm_flag_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = 1'b0;
      complete     = 1'b0;

      vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
      at_vote = os_tick && (samp_cnt_q == OS_W'(SAMP_C));
      accept  = rx_valid_q & rx_ready;

      // The sample counter runs through each bit period while a frame is active.
      if (os_tick && state_q != ST_IDLE) begin
         if (samp_cnt_q == OS_W'(SAMP_A)) samp_d[0] = rx_s_q;
         if (samp_cnt_q == OS_W'(SAMP_B)) samp_d[1] = rx_s_q;
         samp_cnt_d = (samp_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + OS_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            if (os_tick && armed_q && !rx_s_q) begin
               state_d    = ST_START;
               par_flag_d = 1'b0;
               frm_flag_d = 1'b0;
            end
         end
         ST_START: begin
            if (at_vote) begin
               if (vote) begin
                  // A high vote means the falling edge was only a glitch.
                  state_d = ST_IDLE;
                  armed_d = 1'b0;
               end else begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         ST_DATA: begin
            if (at_vote) begin
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (at_vote) begin
               // Odd parity wants an odd total of ones, even parity an even total.
               par_flag_d = (PARITY == 1) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
               state_d    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (at_vote) begin
               if (!vote) frm_flag_d = 1'b1;
               if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                  // Finish at the centre of the last stop bit so that a
                  // back-to-back start edge is not missed. The line must go
                  // high again before the next frame can start, so a break
                  // produces only one word.
                  complete  = 1'b1;
                  state_d   = ST_IDLE;
                  armed_d   = 1'b0;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            armed_d = 1'b0;
         end
      endcase

      // A new word is loaded if the slot is free or is being freed this
      // cycle. Otherwise the new word is dropped and the held word is kept.
      if (complete && (!rx_valid_q || accept)) begin
         rx_data_d    = shift_d;
         rx_valid_d   = 1'b1;
         parity_err_d = par_flag_d;
         frame_err_d  = frm_flag_d;
      end else if (complete) begin
         overrun_d = 1'b1;
      end else if (accept) begin
         rx_valid_d = 1'b0;
      end
   end

   // State registers; synchroniser flops reset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q        <= '0;
         sync1_q      <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= ST_IDLE;
         armed_q      <= 1'b0;
         samp_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         samp_q       <= '0;
         shift_q      <= '0;
         par_flag_q   <= 1'b0;
         frm_flag_q   <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop update from the pre-edge values.
         div_q        <= div_d;
         sync1_q      <= sync1_d;
         rx_s_q       <= rx_s_d;
         state_q      <= state_d;
         armed_q      <= armed_d;
         samp_cnt_q   <= samp_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         samp_q       <= samp_d;
         shift_q      <= shift_d;
         par_flag_q   <= par_flag_d;
         frm_flag_q   <= frm_flag_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg. There are three instances at 16 clk/bit:
// 8N1, 7E1 and 8N2. Each instance has its own rx line and consumer.
module tb_uart_rx_cfg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
   logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

   logic [7:0] a_data;  logic a_valid, a_pe, a_fe, a_ovr, a_busy;
   logic [6:0] b_data;  logic b_valid, b_pe, b_fe, b_ovr, b_busy;
   logic [7:0] c_data;  logic c_valid, c_pe, c_fe, c_ovr, c_busy;

   uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(a_data), .rx_valid(a_valid),
      .rx_ready(ready_a), .parity_err(a_pe), .frame_err(a_fe), .overrun(a_ovr), .busy(a_busy));

   uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(b_data), .rx_valid(b_valid),
      .rx_ready(ready_b), .parity_err(b_pe), .frame_err(b_fe), .overrun(b_ovr), .busy(b_busy));

   uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .rx(rx_c), .rx_data(c_data), .rx_valid(c_valid),
      .rx_ready(ready_c), .parity_err(c_pe), .frame_err(c_fe), .overrun(c_ovr), .busy(c_busy));

   int checks = 0;
   int failures = 0;

   // Consumer-side log per instance, sampled on the falling edge.
   int         acc_cnt[3]   = '{0, 0, 0};
   int         vld_cnt[3]   = '{0, 0, 0};
   int         ovr_cnt[3]   = '{0, 0, 0};
   logic [8:0] last_data[3] = '{9'h0, 9'h0, 9'h0};
   logic       last_pe[3]   = '{1'b0, 1'b0, 1'b0};
   logic       last_fe[3]   = '{1'b0, 1'b0, 1'b0};

   task automatic mon(input int i, input logic v, input logic r, input logic [8:0] d,
                      input logic pe, input logic fe, input logic ov);
      if (v) vld_cnt[i]++;
      if (ov) ovr_cnt[i]++;
      if (v && r) begin
         acc_cnt[i]++;
         last_data[i] = d;
         last_pe[i]   = pe;
         last_fe[i]   = fe;
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_valid, ready_a, {1'b0, a_data}, a_pe, a_fe, a_ovr);
      mon(1, b_valid, ready_b, {2'b0, b_data}, b_pe, b_fe, b_ovr);
      mon(2, c_valid, ready_c, {1'b0, c_data}, c_pe, c_fe, c_ovr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge, well away from both edges.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drive(input int sel, input logic v);
      case (sel)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   // One bit period. An optional 1-clk inverted spike lands on the centre sample.
   task automatic send_bit(input int sel, input logic v, input logic spike);
      drive(sel, v);
      if (spike) begin
         step(9);
         drive(sel, ~v);
         step(1);
         drive(sel, v);
         step(6);
      end else begin
         step(16);
      end
   endtask

   task automatic send(input int sel, input logic [8:0] d, input int nd, input bit use_par,
                       input logic par, input int nstop, input logic [1:0] stops,
                       input logic [8:0] spikes);
      send_bit(sel, 1'b0, 1'b0);
      for (int i = 0; i < nd; i++) send_bit(sel, d[i], spikes[i]);
      if (use_par) send_bit(sel, par, 1'b0);
      for (int s = 0; s < nstop; s++) send_bit(sel, stops[s], 1'b0);
      drive(sel, 1'b1);
   endtask

   int base_acc;
   int base_vld;
   int base_ovr;
   logic [7:0] word7e;

   initial begin
      // Reset state
      step(3);
      check("rst_valid", a_valid, 0);
      check("rst_data", a_data, 0);
      check("rst_pe", a_pe, 0);
      check("rst_fe", a_fe, 0);
      check("rst_ovr", a_ovr, 0);
      check("rst_busy", a_busy, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_c_busy", c_busy, 0);
      rst_n = 1'b1;
      step(5);

      // 1. 8N1 0xA5 with the consumer always ready
      base_acc = acc_cnt[0];
      base_vld = vld_cnt[0];
      send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, 9'h0);
      step(16);
      check("t1_acc_cnt", acc_cnt[0] - base_acc, 1);
      check("t1_data", last_data[0], 9'h0A5);
      check("t1_pe", last_pe[0], 0);
      check("t1_fe", last_fe[0], 0);
      check("t1_valid_cycles", vld_cnt[0] - base_vld, 1);
      check("t1_busy_idle", a_busy, 0);

      // 2. 7E1: 0x53 has four ones, so the correct even parity bit is 0
      base_acc = acc_cnt[1];
      send(1, 9'h053, 7, 1'b1, 1'b0, 1, 2'b11, 9'h0);
      step(16);
      check("t2_good_acc", acc_cnt[1] - base_acc, 1);
      check("t2_good_data", last_data[1], 9'h053);
      check("t2_good_pe", last_pe[1], 0);
      check("t2_good_fe", last_fe[1], 0);
      send(1, 9'h053, 7, 1'b1, 1'b1, 1, 2'b11, 9'h0);
      step(16);
      check("t2_bad_acc", acc_cnt[1] - base_acc, 2);
      check("t2_bad_data", last_data[1], 9'h053);
      check("t2_bad_pe", last_pe[1], 1);

      // 3. Overrun: consumer stalled, two back-to-back frames
      ready_a = 1'b0;
      base_acc = acc_cnt[0];
      base_ovr = ovr_cnt[0];
      send(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11, 9'h0);
      send(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11, 9'h0);
      step(16);
      check("t3_held_valid", a_valid, 1);
      check("t3_held_data", a_data, 8'h11);
      check("t3_ovr_cycles", ovr_cnt[0] - base_ovr, 1);
      ready_a = 1'b1;
      step(1);
      check("t3_valid_drop", a_valid, 0);
      check("t3_acc_cnt", acc_cnt[0] - base_acc, 1);
      check("t3_acc_data", last_data[0], 9'h011);

      // 4a. 4-clk low glitch on an idle line
      step(16);
      base_vld = vld_cnt[0];
      drive(0, 1'b0);
      step(4);
      check("t4_glitch_busy", a_busy, 1);
      drive(0, 1'b1);
      step(16);
      check("t4_glitch_idle", a_busy, 0);
      check("t4_glitch_no_valid", vld_cnt[0] - base_vld, 0);

      // 4b. 1-clk spikes on the centre sample of data bits 2 and 5 of 0x3C;
      //     the word is left pending for the reset test
      ready_a = 1'b0;
      send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b11, 9'b000100100);
      step(16);
      check("t4_spike_valid", a_valid, 1);
      check("t4_spike_data", a_data, 8'h3C);
      check("t4_spike_fe", a_fe, 0);

      // 5a. 8N2 with the second stop bit low
      base_acc = acc_cnt[2];
      send(2, 9'h05A, 8, 1'b0, 1'b0, 2, 2'b01, 9'h0);
      step(16);
      check("t5_acc_cnt", acc_cnt[2] - base_acc, 1);
      check("t5_data", last_data[2], 9'h05A);
      check("t5_fe", last_fe[2], 1);

      // 5b. Break: line low for 20 bit times gives one zero word with frame_err
      base_acc = acc_cnt[2];
      drive(2, 1'b0);
      step(320);
      check("t5_brk_acc_cnt", acc_cnt[2] - base_acc, 1);
      check("t5_brk_data", last_data[2], 9'h000);
      check("t5_brk_fe", last_fe[2], 1);
      check("t5_brk_busy", c_busy, 0);
      drive(2, 1'b1);
      step(32);
      check("t5_brk_no_repeat", acc_cnt[2] - base_acc, 1);

      // 6. Reset in the middle of data bit 3 of 0x7E while 0x3C is still pending
      word7e = 8'h7E;
      send_bit(0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(0, word7e[i], 1'b0);
      drive(0, word7e[3]);
      step(8);
      check("t6_busy_before", a_busy, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", a_valid, 0);
      check("t6_rst_data", a_data, 0);
      check("t6_rst_busy", a_busy, 0);
      check("t6_rst_fe", a_fe, 0);
      drive(0, 1'b1);
      step(3);
      rst_n = 1'b1;
      step(4);
      ready_a = 1'b1;
      base_acc = acc_cnt[0];
      send(0, 9'h081, 8, 1'b0, 1'b0, 1, 2'b11, 9'h0);
      step(16);
      check("t6_acc_cnt", acc_cnt[0] - base_acc, 1);
      check("t6_data", last_data[0], 9'h081);
      check("t6_fe", last_fe[0], 0);
      check("t6_pe", last_pe[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
